// File: rtl/dco_freq_counter.sv
// dco_freq_counter: counts DCO rising edges over a programmable clk-cycle window
module dco_freq_counter #(
  parameter int GATE_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              dco_in,
  input  logic [GATE_W-1:0] gate_cycles,
  input  logic              start,
  input  logic              continuous,
  output logic [CNT_W-1:0]  count_out,
  output logic              count_valid,
  output logic              overflow,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, ARM, MEASURE, DONE} state_t;
  state_t state, state_nxt;
  logic sync1, sync2, dly, dco_edge, accept, ovf_acc, ovf_nxt;
  logic [GATE_W-1:0] gate_len, gate_cnt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  assign dco_edge = sync2 & ~dly;
  assign busy = state != IDLE;
  assign accept = ena && start && gate_cycles != '0;
  // the final window cycle's edge is folded in so the result lands on entry to DONE
  always_comb begin
    cnt_nxt = cnt;
    ovf_nxt = ovf_acc;
    if (state == MEASURE && dco_edge) begin
      if (&cnt) ovf_nxt = 1'b1;
      else cnt_nxt = cnt + 1'b1;
    end
    state_nxt = !ena ? IDLE :
                state == IDLE ? (accept ? ARM : IDLE) :
                state == ARM ? MEASURE :
                state == MEASURE ? (gate_cnt == GATE_W'(1) ? DONE : MEASURE) :
                (continuous ? ARM : IDLE);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      sync1       <= 1'b0;
      sync2       <= 1'b0;
      dly         <= 1'b0;
      gate_len    <= '0;
      gate_cnt    <= '0;
      cnt         <= '0;
      ovf_acc     <= 1'b0;
      count_out   <= '0;
      count_valid <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      state <= state_nxt;
      sync1 <= dco_in;
      sync2 <= sync1;
      dly   <= sync2;
      if (state == IDLE && accept) gate_len <= gate_cycles;
      if (state == ARM) begin
        cnt      <= '0;
        ovf_acc  <= 1'b0;
        gate_cnt <= gate_len;
      end else if (state == MEASURE) begin
        cnt      <= cnt_nxt;
        ovf_acc  <= ovf_nxt;
        gate_cnt <= gate_cnt - 1'b1;
      end
      count_valid <= state_nxt == DONE;
      if (state_nxt == DONE) begin
        count_out <= cnt_nxt;
        overflow  <= ovf_nxt;
      end
    end
  end
endmodule

// File: tb/tb_dco_freq_counter.sv
// tb_dco_freq_counter: directed checks with a full-width and a 4-bit counter instance
module tb_dco_freq_counter;
  logic clk = 1'b0, rst_n = 1'b0, ena = 1'b0, dco_in, start = 1'b0, continuous = 1'b0;
  logic [15:0] gate_cycles = '0, count_out;
  logic [3:0] count_s;
  logic count_valid, overflow, busy, valid_s, ovf_s, busy_s;
  int n_cmp = 0, n_err = 0, per = 4;
  logic [3:0] div = '0;

  always #5 clk = ~clk;
  always @(posedge clk) div <= (int'(div) >= per - 1) ? 4'd0 : div + 4'd1;
  assign dco_in = int'(div) < per / 2;

  dco_freq_counter u_dut (.clk(clk), .rst_n(rst_n), .ena(ena), .dco_in(dco_in),
    .gate_cycles(gate_cycles), .start(start), .continuous(continuous),
    .count_out(count_out), .count_valid(count_valid), .overflow(overflow), .busy(busy));
  dco_freq_counter #(.GATE_W(16), .CNT_W(4)) u_small (.clk(clk), .rst_n(rst_n), .ena(ena),
    .dco_in(dco_in), .gate_cycles(gate_cycles), .start(start), .continuous(continuous),
    .count_out(count_s), .count_valid(valid_s), .overflow(ovf_s), .busy(busy_s));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic shot(input logic [15:0] g, output int lat);
    gate_cycles = g;
    start = 1'b1;
    tick;
    start = 1'b0;
    lat = 1;
    while (!count_valid && lat < 400) begin
      tick;
      lat++;
    end
  endtask

  initial begin
    int lat, nv, seen;
    int sweep_per[3] = '{4, 6, 10};
    int sweep_exp[3] = '{30, 20, 12};
    repeat (3) tick;
    rst_n = 1'b1;
    ena = 1'b1;
    seen = 0;
    repeat (50) begin
      tick;
      if (count_valid || busy || overflow || count_out != 0) seen++;
    end
    check("idle_quiet_cycles", seen, 0);
    check("idle_count_out", count_out, 0);
    check("idle_busy", busy, 0);

    per = 4;
    repeat (10) tick;
    gate_cycles = 100;
    start = 1'b1;
    tick;
    start = 1'b0;
    check("ss_busy_rise", busy, 1);
    lat = 1;
    while (!count_valid && lat < 400) begin
      tick;
      lat++;
    end
    check("ss_latency", lat, 102);
    check("ss_count", count_out, 25);
    check("ss_ovf", overflow, 0);
    check("sat_count", count_s, 15);
    check("sat_ovf", ovf_s, 1);
    check("sat_valid", valid_s, 1);
    tick;
    check("ss_busy_fall", busy, 0);
    check("ss_valid_pulse", count_valid, 0);

    shot(16'd20, lat);
    check("g20_latency", lat, 22);
    check("g20_count", count_out, 5);
    check("g20_small_count", count_s, 5);
    check("g20_small_ovf", ovf_s, 0);

    per = 8;
    repeat (10) tick;
    continuous = 1'b1;
    shot(16'd16, lat);
    check("cont_first_latency", lat, 18);
    check("cont_count0", count_out, 2);
    for (int k = 1; k <= 3; k++) begin
      tick;
      lat = 1;
      while (!count_valid && lat < 100) begin
        tick;
        lat++;
      end
      check($sformatf("cont_period%0d", k), lat, 18);
      check($sformatf("cont_count%0d", k), count_out, 2);
    end
    tick;
    continuous = 1'b0;
    nv = 0;
    repeat (60) begin
      tick;
      if (count_valid) nv++;
    end
    check("cont_tail_valids", nv, 1);
    check("cont_tail_busy", busy, 0);

    per = 4;
    repeat (10) tick;
    gate_cycles = 100;
    start = 1'b1;
    tick;
    start = 1'b0;
    repeat (30) tick;
    ena = 1'b0;
    tick;
    check("abort_busy", busy, 0);
    ena = 1'b1;
    nv = 0;
    repeat (150) begin
      tick;
      if (count_valid) nv++;
    end
    check("abort_valids", nv, 0);
    check("abort_hold", count_out, 2);

    gate_cycles = 0;
    start = 1'b1;
    nv = 0;
    seen = 0;
    repeat (5) begin
      tick;
      if (busy) seen++;
      if (count_valid) nv++;
    end
    start = 1'b0;
    check("zero_gate_busy", seen, 0);
    check("zero_gate_valids", nv, 0);

    for (int i = 0; i < 3; i++) begin
      per = sweep_per[i];
      repeat (20) tick;
      gate_cycles = 120;
      start = 1'b1;
      tick;
      start = 1'b0;
      gate_cycles = 5;
      lat = 1;
      while (!count_valid && lat < 400) begin
        tick;
        lat++;
      end
      check($sformatf("sweep_lat_p%0d", sweep_per[i]), lat, 122);
      check($sformatf("sweep_cnt_p%0d", sweep_per[i]), count_out, sweep_exp[i]);
    end

    gate_cycles = 100;
    start = 1'b1;
    tick;
    start = 1'b0;
    repeat (20) tick;
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_count", count_out, 0);
    check("arst_busy", busy, 0);
    check("arst_valid", count_valid, 0);
    check("arst_ovf", ovf_s, 0);
    rst_n = 1'b1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
